// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned LEGAL_MASK_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Byte, half, word and double write masks; anything else is rejected.
  localparam logic [LEGAL_MASK_BITS-1:0] MASK_B = 8'h01;
  localparam logic [LEGAL_MASK_BITS-1:0] MASK_H = 8'h03;
  localparam logic [LEGAL_MASK_BITS-1:0] MASK_W = 8'h0F;
  localparam logic [LEGAL_MASK_BITS-1:0] MASK_D = 8'hFF;

  function automatic logic mask_legal(input logic [LEGAL_MASK_BITS-1:0] m);
    return (m == MASK_B) || (m == MASK_H) || (m == MASK_W) || (m == MASK_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response channels for IFU and LSU plus the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = 8
);

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic              ifu_resp_ready;
  logic [DATA_W-1:0] ifu_resp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_wen;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_resp_valid;
  logic              lsu_resp_ready;
  logic [DATA_W-1:0] lsu_resp_rdata;
  logic              lsu_resp_err;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_we_en;
  logic [ADDR_W-1:0] mem_we_addr;
  logic [DATA_W-1:0] mem_we_data;
  logic [MASK_W-1:0] mem_we_mask;

  // Arbiter side.
  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_resp_ready, mem_rd_data,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );

  // Core pipeline and memory side.
  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_resp_ready, mem_rd_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  mem_rd_en, mem_rd_addr, mem_we_en, mem_we_addr, mem_we_data, mem_we_mask
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// requester that was not served last. req/gnt bit 0 = IFU, bit 1 = LSU.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

  // Purely combinational one-hot grant.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == OWN_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU (read-only) and LSU (read/write),
// one transaction in flight: IDLE -> ISSUE -> (CAPT) -> RESP -> IDLE.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MASK_W = 8
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            rr_last_q, rr_last_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;

  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              mem_we_en_q, mem_we_en_d;
  logic [ADDR_W-1:0] mem_we_addr_q, mem_we_addr_d;
  logic [DATA_W-1:0] mem_we_data_q, mem_we_data_d;
  logic [MASK_W-1:0] mem_we_mask_q, mem_we_mask_d;

  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic [DATA_W-1:0] ifu_resp_data_q, ifu_resp_data_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_W-1:0] lsu_resp_rdata_q, lsu_resp_rdata_d;
  logic              lsu_resp_err_q, lsu_resp_err_d;

  logic              ifu_req_ready_c, lsu_req_ready_c;
  logic [1:0]        gnt;
  logic              wmask_ok;

  rr_arb2 u_rr_arb2 (
    .req  ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last (rr_last_q),
    .gnt  (gnt)
  );

  assign wmask_ok = mask_legal(8'(bus.lsu_req_wmask));

  // State, latched request info and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      rr_last_q        <= OWN_LSU;
      wen_q            <= 1'b0;
      err_q            <= 1'b0;
      mem_rd_en_q      <= 1'b0;
      mem_rd_addr_q    <= '0;
      mem_we_en_q      <= 1'b0;
      mem_we_addr_q    <= '0;
      mem_we_data_q    <= '0;
      mem_we_mask_q    <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_rdata_q <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      rr_last_q        <= rr_last_d;
      wen_q            <= wen_d;
      err_q            <= err_d;
      mem_rd_en_q      <= mem_rd_en_d;
      mem_rd_addr_q    <= mem_rd_addr_d;
      mem_we_en_q      <= mem_we_en_d;
      mem_we_addr_q    <= mem_we_addr_d;
      mem_we_data_q    <= mem_we_data_d;
      mem_we_mask_q    <= mem_we_mask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_rdata_q <= lsu_resp_rdata_d;
      lsu_resp_err_q   <= lsu_resp_err_d;
    end
  end

  // Next state, next registered outputs and the combinational request readies.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_last_d        = rr_last_q;
    wen_d            = wen_q;
    err_d            = err_q;
    mem_rd_en_d      = 1'b0;
    mem_rd_addr_d    = '0;
    mem_we_en_d      = 1'b0;
    mem_we_addr_d    = '0;
    mem_we_data_d    = '0;
    mem_we_mask_d    = '0;
    ifu_resp_valid_d = ifu_resp_valid_q;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = lsu_resp_valid_q;
    lsu_resp_rdata_d = lsu_resp_rdata_q;
    lsu_resp_err_d   = lsu_resp_err_q;
    ifu_req_ready_c  = 1'b0;
    lsu_req_ready_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Readies drop for the loser of a tie; held low while in reset.
        ifu_req_ready_c = ~rst & ~gnt[1];
        lsu_req_ready_c = ~rst & ~gnt[0];
        if (gnt[0]) begin
          owner_d       = OWN_IFU;
          rr_last_d     = OWN_IFU;
          wen_d         = 1'b0;
          err_d         = 1'b0;
          mem_rd_en_d   = 1'b1;
          mem_rd_addr_d = bus.ifu_req_addr;
          state_d       = ISSUE;
        end else if (gnt[1]) begin
          owner_d   = OWN_LSU;
          rr_last_d = OWN_LSU;
          wen_d     = bus.lsu_req_wen;
          err_d     = bus.lsu_req_wen & ~wmask_ok;
          if (!bus.lsu_req_wen) begin
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = bus.lsu_req_addr;
          end else if (wmask_ok) begin
            mem_we_en_d   = 1'b1;
            mem_we_addr_d = bus.lsu_req_addr;
            mem_we_data_d = bus.lsu_req_wdata;
            mem_we_mask_d = bus.lsu_req_wmask;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Writes (legal or suppressed) respond directly; reads wait for data.
        if (wen_q) begin
          lsu_resp_valid_d = 1'b1;
          lsu_resp_rdata_d = '0;
          lsu_resp_err_d   = err_q;
          state_d          = RESP;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        // Memory clears rd_data on the next edge, so capture it now.
        if (owner_q == OWN_IFU) begin
          ifu_resp_valid_d = 1'b1;
          ifu_resp_data_d  = bus.mem_rd_data;
        end else begin
          lsu_resp_valid_d = 1'b1;
          lsu_resp_rdata_d = bus.mem_rd_data;
          lsu_resp_err_d   = 1'b0;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_q == OWN_IFU) begin
          if (bus.ifu_resp_ready) begin
            ifu_resp_valid_d = 1'b0;
            ifu_resp_data_d  = '0;
            state_d          = IDLE;
          end
        end else if (bus.lsu_resp_ready) begin
          lsu_resp_valid_d = 1'b0;
          lsu_resp_rdata_d = '0;
          lsu_resp_err_d   = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ifu_req_ready  = ifu_req_ready_c;
  assign bus.lsu_req_ready  = lsu_req_ready_c;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_resp_data  = ifu_resp_data_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_resp_rdata = lsu_resp_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign bus.mem_rd_en      = mem_rd_en_q;
  assign bus.mem_rd_addr    = mem_rd_addr_q;
  assign bus.mem_we_en      = mem_we_en_q;
  assign bus.mem_we_addr    = mem_we_addr_q;
  assign bus.mem_we_data    = mem_we_data_q;
  assign bus.mem_we_mask    = mem_we_mask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small registered-read memory model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  localparam logic [63:0] A_FETCH = 64'h0000_0000_8000_0000;
  localparam logic [63:0] A_DATA  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] D_FETCH = 64'h0000_0413_0000_0297;
  localparam logic [63:0] D_DATA  = 64'h0000_0000_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int we_cnt = 0;
  logic [64:0] resp_log[$];
  logic [63:0] mem [16];

  function automatic logic [3:0] midx(input logic [63:0] a);
    return {a[12], a[5:3]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory: read data valid the cycle after rd_en, zero otherwise; masked writes.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[midx(A_FETCH)] <= D_FETCH;
    end else if (bus.mem_we_en) begin
      mem[midx(bus.mem_we_addr)] <= merge(mem[midx(bus.mem_we_addr)], bus.mem_we_data,
                                          bus.mem_we_mask);
    end
    bus.mem_rd_data <= bus.mem_rd_en ? mem[midx(bus.mem_rd_addr)] : '0;
  end

  // Count memory accesses and log completed responses (owner bit, data).
  always @(negedge clk) begin
    if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.mem_we_en) we_cnt <= we_cnt + 1;
    if (bus.ifu_resp_valid && bus.ifu_resp_ready) resp_log.push_back({1'b0, bus.ifu_resp_data});
    if (bus.lsu_resp_valid && bus.lsu_resp_ready) resp_log.push_back({1'b1, bus.lsu_resp_rdata});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts edges since the handshake edge (1 on entry).
  task automatic wait_resp(input bit lsu, inout int lat);
    while (((lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid) == 1'b0) && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  task automatic lsu_drive(input logic [63:0] a, input logic wen, input logic [63:0] d,
                           input logic [7:0] m);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_addr  = a;
    bus.lsu_req_wen   = wen;
    bus.lsu_req_wdata = d;
    bus.lsu_req_wmask = m;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, r0, w0, n0, cyc;
    logic [64:0] e;
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_req_addr   = '0;
    bus.ifu_resp_ready = 1'b1;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_addr   = '0;
    bus.lsu_req_wen    = 1'b0;
    bus.lsu_req_wdata  = '0;
    bus.lsu_req_wmask  = '0;
    bus.lsu_resp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outputs", {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid,
             bus.lsu_resp_valid, bus.lsu_resp_err, bus.mem_rd_en, bus.mem_we_en}, 0);
    check_eq("rst_mem_bus", bus.mem_rd_addr | bus.mem_we_addr | bus.mem_we_data, 0);
    mem_init = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("idle_readies", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b11);

    // IFU read
    r0 = rd_cnt;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = A_FETCH;
    #1;
    check_eq("ifu_req_ready", bus.ifu_req_ready, 1);
    tick();
    bus.ifu_req_valid = 1'b0;
    check_eq("ifu_issue_rd", {bus.mem_rd_en, bus.mem_we_en}, 2'b10);
    check_eq("ifu_rd_addr", bus.mem_rd_addr, A_FETCH);
    lat = 1;
    wait_resp(1'b0, lat);
    check_eq("ifu_rd_latency", 64'(lat), 3);
    check_eq("ifu_rd_data", bus.ifu_resp_data, D_FETCH);
    check_eq("resp_readies", {bus.ifu_req_ready, bus.lsu_req_ready}, 0);
    tick();
    check_eq("ifu_idle_after", {bus.ifu_resp_valid, bus.ifu_req_ready}, 2'b01);
    check_eq("ifu_data_cleared", bus.ifu_resp_data, 0);
    check_eq("ifu_rd_pulses", 64'(rd_cnt - r0), 1);

    // LSU word write
    w0 = we_cnt;
    lsu_drive(A_DATA, 1'b1, 64'h0000_0000_DEAD_BEEF, 8'h0F);
    #1;
    check_eq("lsu_req_ready", bus.lsu_req_ready, 1);
    tick();
    bus.lsu_req_valid = 1'b0;
    check_eq("wr_issue", {bus.mem_we_en, bus.mem_rd_en, bus.mem_we_mask}, {2'b10, 8'h0F});
    check_eq("wr_addr", bus.mem_we_addr, A_DATA);
    check_eq("wr_data", bus.mem_we_data, 64'h0000_0000_DEAD_BEEF);
    lat = 1;
    wait_resp(1'b1, lat);
    check_eq("wr_latency", 64'(lat), 2);
    check_eq("wr_resp", {bus.lsu_resp_err, bus.mem_we_en}, 0);
    check_eq("wr_rdata_zero", bus.lsu_resp_rdata, 0);
    tick();
    check_eq("wr_pulses", 64'(we_cnt - w0), 1);

    // LSU read back
    lsu_drive(A_DATA, 1'b0, '0, '0);
    tick();
    bus.lsu_req_valid = 1'b0;
    lat = 1;
    wait_resp(1'b1, lat);
    check_eq("lsu_rd_latency", 64'(lat), 3);
    check_eq("lsu_rd_data", bus.lsu_resp_rdata, D_DATA);
    tick();

    // Illegal write mask
    w0 = we_cnt;
    lsu_drive(A_DATA, 1'b1, 64'h0000_0000_1234_5678, 8'h06);
    tick();
    bus.lsu_req_valid = 1'b0;
    check_eq("bad_mask_no_we", bus.mem_we_en, 0);
    lat = 1;
    wait_resp(1'b1, lat);
    check_eq("bad_mask_latency", 64'(lat), 2);
    check_eq("bad_mask_err", bus.lsu_resp_err, 1);
    tick();
    check_eq("bad_mask_err_clr", bus.lsu_resp_err, 0);
    check_eq("bad_mask_pulses", 64'(we_cnt - w0), 0);

    // Contention: last grant was LSU, so IFU leads and grants alternate
    n0 = resp_log.size();
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = A_FETCH;
    lsu_drive(A_DATA, 1'b0, '0, '0);
    #1;
    check_eq("tie_readies", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b10);
    cyc = 0;
    while ((resp_log.size() - n0) < 4 && cyc < 40) begin
      tick();
      cyc++;
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    repeat (6) tick();
    check_eq("tie_resp_count", 64'(resp_log.size() - n0), 4);
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < resp_log.size()) e = resp_log[n0 + i];
      else e = '1;
      check_eq($sformatf("tie_owner%0d", i), 64'(e[64]), 64'(i % 2));
      check_eq($sformatf("tie_data%0d", i), e[63:0], (i % 2 == 0) ? D_FETCH : D_DATA);
    end

    // Backpressure on the IFU response
    r0 = rd_cnt;
    bus.ifu_resp_ready = 1'b0;
    bus.ifu_req_valid  = 1'b1;
    bus.ifu_req_addr   = A_FETCH;
    tick();
    bus.ifu_req_valid = 1'b0;
    lat = 1;
    wait_resp(1'b0, lat);
    check_eq("bp_latency", 64'(lat), 3);
    lsu_drive(A_DATA, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq($sformatf("bp_hold%0d", k),
               {bus.ifu_resp_valid, bus.ifu_req_ready, bus.lsu_req_ready}, 3'b100);
      check_eq($sformatf("bp_data%0d", k), bus.ifu_resp_data, D_FETCH);
    end
    check_eq("bp_no_new_rd", 64'(rd_cnt - r0), 1);
    bus.ifu_resp_ready = 1'b1;
    tick();
    check_eq("bp_release", {bus.ifu_resp_valid, bus.lsu_req_ready}, 2'b01);
    bus.lsu_req_valid = 1'b0;
    repeat (4) tick();
    check_eq("dropped_lsu_unserved", bus.lsu_resp_valid, 0);

    // Async reset while mem_rd_en is high clears it without an edge
    r0 = rd_cnt;
    bus.ifu_req_valid = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_issue_rd_en", bus.mem_rd_en, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check_eq("rst_issue_no_rd", 64'(rd_cnt - r0), 0);

    // Async reset in CAPT drops the transaction
    r0 = rd_cnt;
    n0 = resp_log.size();
    bus.ifu_req_valid = 1'b1;
    tick();
    bus.ifu_req_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_capt_outputs", {bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid,
             bus.lsu_resp_valid, bus.mem_rd_en, bus.mem_we_en}, 0);
    tick();
    check_eq("rst_capt_held", {bus.ifu_resp_valid, bus.ifu_resp_data}, 0);
    #2 rst = 1'b0;
    #1;
    check_eq("rst_capt_idle", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b11);
    repeat (5) tick();
    check_eq("rst_capt_no_resp", 64'(resp_log.size() - n0), 0);
    check_eq("rst_capt_rd_count", 64'(rd_cnt - r0), 1);

    // Normal service after reset
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr  = A_FETCH;
    tick();
    bus.ifu_req_valid = 1'b0;
    lat = 1;
    wait_resp(1'b0, lat);
    check_eq("post_rst_latency", 64'(lat), 3);
    check_eq("post_rst_data", bus.ifu_resp_data, D_FETCH);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
